// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative RV32M multiply/divide engine for the EX stage.
//                Shift-add multiply and restoring divide on operand
//                magnitudes. The unit stalls the pipeline while it computes
//                and pulses done_o for the cycle in which EX/MEM captures
//                the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [NBITS-1:0] rs1_i,
    input  logic [NBITS-1:0] rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic [NBITS-1:0] result_o,
    output logic [4:0]       rd_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             stall_o
);

    localparam int CW = $clog2(NBITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NBITS-1:0] c_min_int = {1'b1, {(NBITS-1){1'b0}}};

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*NBITS-1:0] acc_q,     acc_d;
    logic [NBITS-1:0]   opb_q,     opb_d;
    logic [2:0]         f3_q,      f3_d;
    logic               neg_q,     neg_d;
    logic [4:0]         rd_pend_q, rd_pend_d;
    logic [NBITS-1:0]   result_q,  result_d;
    logic [4:0]         rd_q,      rd_d;

    // Operand decode at issue: signedness, magnitudes, result sign, special cases
    logic             w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [NBITS-1:0] w_a_mag, w_b_mag, w_special_res;
    logic             w_div_zero, w_ovf, w_sign;

    always_comb begin
        w_is_div   = funct3_i[2];
        w_a_signed = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                     (funct3_i == 3'd4) || (funct3_i == 3'd6);
        w_b_signed = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        w_a_neg    = w_a_signed & rs1_i[NBITS-1];
        w_b_neg    = w_b_signed & rs2_i[NBITS-1];
        w_a_mag    = w_a_neg ? ('0 - rs1_i) : rs1_i;
        w_b_mag    = w_b_neg ? ('0 - rs2_i) : rs2_i;
        w_div_zero = w_is_div & (rs2_i == '0);
        w_ovf      = w_is_div & ~funct3_i[0] & (rs1_i == c_min_int) & (rs2_i == '1);
        // Remainder follows the dividend; products and quotients follow the sign XOR
        w_sign     = (w_is_div & funct3_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        if (w_div_zero)
            w_special_res = funct3_i[1] ? rs1_i : '1;
        else
            w_special_res = funct3_i[1] ? '0 : rs1_i;   // overflow: quotient = INT_MIN
    end

    // One iteration of shift-add multiply or restoring divide on acc = {hi, lo}
    logic [NBITS:0]     w_sum, w_shift, w_diff;
    logic               w_qbit;
    logic [2*NBITS-1:0] w_mul_next, w_div_next, w_step, w_mul_full;
    logic [NBITS-1:0]   w_div_raw, w_final;

    always_comb begin
        w_sum      = {1'b0, acc_q[2*NBITS-1:NBITS]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        w_mul_next = {w_sum, acc_q[NBITS-1:1]};
        w_shift    = acc_q[2*NBITS-1:NBITS-1];
        w_diff     = w_shift - {1'b0, opb_q};
        w_qbit     = ~w_diff[NBITS];
        w_div_next = {(w_qbit ? w_diff[NBITS-1:0] : w_shift[NBITS-1:0]),
                      acc_q[NBITS-2:0], w_qbit};
        w_step     = f3_q[2] ? w_div_next : w_mul_next;
        w_mul_full = neg_q ? ('0 - w_step) : w_step;
        w_div_raw  = f3_q[1] ? w_step[2*NBITS-1:NBITS] : w_step[NBITS-1:0];
        if (f3_q[2])
            w_final = neg_q ? ('0 - w_div_raw) : w_div_raw;
        else if (f3_q[1:0] == 2'd0)
            w_final = w_mul_full[NBITS-1:0];
        else
            w_final = w_mul_full[2*NBITS-1:NBITS];
    end

    // Next-state logic; flush overrides everything and preserves visible outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        rd_pend_d = rd_pend_q;
        result_d  = result_q;
        rd_d      = rd_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    f3_d      = funct3_i;
                    rd_pend_d = rd_i;
                    neg_d     = w_sign;
                    if (w_div_zero || w_ovf) begin
                        result_d = w_special_res;
                        rd_d     = rd_i;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {{NBITS{1'b0}}, w_a_mag};
                        opb_d   = w_b_mag;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = w_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NBITS-1)) begin
                    result_d = w_final;
                    rd_d     = rd_pend_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // start_i still shows the op that is finishing; do not re-accept it
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
            rd_d     = rd_q;
        end
    end

    // State and datapath registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            rd_pend_q <= '0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            rd_pend_q <= rd_pend_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    assign result_o = result_q;
    assign rd_o     = rd_q;
    assign done_o   = (state_q == S_DONE);
    assign busy_o   = (state_q == S_RUN);
    assign stall_o  = start_i & ~done_o & ~flush_i;

endmodule
`default_nettype wire
